// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahbl_bus_mux_if.sv
// AHB-Lite bus bundle between the master, the slaves and the interconnect.
interface ahbl_bus_mux_if #(
  parameter int NUM_SLAVES = 6
);
  logic [31:0]              HADDR;
  logic [1:0]               HTRANS;
  logic                     HREADY;
  logic [31:0]              HRDATA;
  logic                     HRESP;
  logic [NUM_SLAVES-1:0]    HSEL;
  logic [NUM_SLAVES-1:0]    HREADY_S;
  logic [32*NUM_SLAVES-1:0] HRDATA_S;
  logic [NUM_SLAVES-1:0]    HRESP_S;

  // slave: the interconnect itself; master: the surrounding master + slaves
  modport slave (
    input  HADDR, HTRANS, HREADY_S, HRDATA_S, HRESP_S,
    output HREADY, HRDATA, HRESP, HSEL
  );

  modport master (
    output HADDR, HTRANS, HREADY_S, HRDATA_S, HRESP_S,
    input  HREADY, HRDATA, HRESP, HSEL
  );
endinterface

// File: rtl/ahbl_default_slave.sv
// Default slave: two-cycle ERROR response for unmapped active transfers.
module ahbl_default_slave
  import ahbl_pkg::*;
(
  input  logic HCLK,
  input  logic HRESET,
  input  logic HREADY,
  input  logic capture,
  input  logic unmapped,
  output logic HREADYOUT,
  output logic HRESP
);

  ds_state_e state, state_nxt;
  logic      take;

  assign take = HREADY & capture & unmapped;

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= DS_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    case (state)
      DS_IDLE: if (take) state_nxt = DS_ERR1;
      DS_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_nxt = DS_ERR2;
      end
      DS_ERR2: begin
        HRESP     = HRESP_ERROR;
        state_nxt = take ? DS_ERR1 : DS_IDLE;
      end
      default: state_nxt = DS_IDLE;
    endcase
  end

endmodule

// File: rtl/ahbl_bus_mux.sv
// AHB-Lite single-master page decoder and data-phase response mux.
// AHBL_BUS_MUX_ERR_EN enables the ERROR-returning default slave.
module ahbl_bus_mux
  import ahbl_pkg::*;
#(
  parameter int                          NUM_SLAVES    = 6,
  parameter int                          PAGE_LSB      = 24,
  parameter int                          PAGE_W        = 8,
  parameter logic [NUM_SLAVES*PAGE_W-1:0] SLV_PAGES    = {8'h40, 8'h4A, 8'h49, 8'h48, 8'h20, 8'h00},
  parameter logic [31:0]                 DEFAULT_RDATA = 32'hDEADBEEF
) (
  input  logic            HCLK,
  input  logic            HRESET,
  ahbl_bus_mux_if.slave   bus
);

  logic [PAGE_W-1:0]     page;
  logic [NUM_SLAVES-1:0] hsel;
  logic [NUM_SLAVES-1:0] dp_sel;
  logic                  active;
  logic                  hready;
  logic                  owner_ready;
  logic                  owner_resp;
  logic [31:0]           owner_rdata;
  logic                  ds_ready;
  logic                  ds_resp;
  logic                  unused_bits;

  assign page   = bus.HADDR[PAGE_LSB +: PAGE_W];
  assign active = bus.HTRANS[1];
  assign unused_bits = ^{bus.HADDR, bus.HTRANS[0]};

  // Scan from the top so the lowest matching index is the last one written.
  always_comb begin
    hsel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (page == SLV_PAGES[i*PAGE_W +: PAGE_W]) begin
        hsel    = '0;
        hsel[i] = 1'b1;
      end
    end
  end

  assign bus.HSEL = hsel;

  always_ff @(posedge HCLK) begin
    if (HRESET)      dp_sel <= '0;
    else if (hready) dp_sel <= active ? hsel : '0;
  end

  always_comb begin
    owner_ready = 1'b1;
    owner_resp  = HRESP_OKAY;
    owner_rdata = DEFAULT_RDATA;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (dp_sel[i]) begin
        owner_ready = bus.HREADY_S[i];
        owner_resp  = bus.HRESP_S[i];
        owner_rdata = bus.HRDATA_S[32*i +: 32];
      end
    end
  end

`ifdef AHBL_BUS_MUX_ERR_EN
  ahbl_default_slave u_def (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HREADY   (hready),
    .capture  (active),
    .unmapped (~|hsel),
    .HREADYOUT(ds_ready),
    .HRESP    (ds_resp)
  );
`else
  assign ds_ready = 1'b1;
  assign ds_resp  = HRESP_OKAY;
`endif

  // The default slave is only busy while no real slave owns the data phase.
  always_comb begin
    if (|dp_sel) begin
      hready = owner_ready;
      bus.HRESP = owner_resp;
    end else begin
      hready = ds_ready;
      bus.HRESP = ds_resp;
    end
  end

  assign bus.HREADY = hready;
  assign bus.HRDATA = owner_rdata;

endmodule

// File: tb/tb_ahbl_bus_mux.sv
// Bench for ahbl_bus_mux: directed test-plan cases plus random traffic vs a transaction model.
module tb_ahbl_bus_mux;
  import ahbl_pkg::*;

  localparam int NS = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ahbl_bus_mux_if #(.NUM_SLAVES(NS)) bus();

  ahbl_bus_mux #(.NUM_SLAVES(NS)) dut (
    .HCLK  (clk),
    .HRESET(rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // Slave pages in index order.
  int pages [NS] = '{8'h00, 8'h20, 8'h48, 8'h49, 8'h4A, 8'h40};

  // Model of the outstanding data phase: 0 none, 1 slave ph_slv, 2 unmapped (ph_cyc = 1/2)
  int ph_kind = 0;
  int ph_slv  = 0;
  int ph_cyc  = 0;

  logic [32*NS-1:0] rd_next;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int dec(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if (int'(a[31:24]) == pages[i]) return i;
    return -1;
  endfunction

  function automatic logic m_ready();
    case (ph_kind)
      1: return bus.HREADY_S[ph_slv];
      2: return (ph_cyc == 2);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic m_resp();
    case (ph_kind)
      1: return bus.HRESP_S[ph_slv];
      2: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] m_rdata();
    if (ph_kind == 1) return bus.HRDATA_S[32*ph_slv +: 32];
    return 32'hDEADBEEF;
  endfunction

  function automatic logic [31:0] m_hsel();
    int d;
    d = dec(bus.HADDR);
    if (d < 0) return 32'd0;
    return 32'd1 << d;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ph_kind <= 0;
    end else if (m_ready()) begin
      if (bus.HTRANS[1] && dec(bus.HADDR) >= 0) begin
        ph_kind <= 1;
        ph_slv  <= dec(bus.HADDR);
      end else if (bus.HTRANS[1]) begin
`ifdef AHBL_BUS_MUX_ERR_EN
        ph_kind <= 2;
        ph_cyc  <= 1;
`else
        ph_kind <= 0;
`endif
      end else begin
        ph_kind <= 0;
      end
    end else if (ph_kind == 2) begin
      ph_cyc <= 2;
    end
  end

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      chk("m_hsel",   32'(bus.HSEL),   m_hsel());
      chk("m_hready", 32'(bus.HREADY), 32'(m_ready()));
      chk("m_hresp",  32'(bus.HRESP),  32'(m_resp()));
      chk("m_hrdata", bus.HRDATA,      m_rdata());
    end
  end

  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic [NS-1:0] r,
                      input logic [NS-1:0] rs, input logic rr);
    @(negedge clk);
    bus.HADDR    = a;
    bus.HTRANS   = t;
    bus.HREADY_S = r;
    bus.HRESP_S  = rs;
    bus.HRDATA_S = rd_next;
    rst          = rr;
    #3;
  endtask

  localparam logic [1:0] IDL = HTRANS_IDLE;
  localparam logic [1:0] NSQ = HTRANS_NONSEQ;

  initial begin
    rst          = 1'b1;
    bus.HADDR    = '0;
    bus.HTRANS   = IDL;
    bus.HREADY_S = '1;
    bus.HRESP_S  = '0;
    for (int i = 0; i < NS; i++) rd_next[32*i +: 32] = $urandom;
    bus.HRDATA_S = rd_next;

    step(32'h0, IDL, '1, '0, 1'b1);
    step(32'h0, IDL, '1, '0, 1'b1);
    chk_en = 1'b1;
    step(32'h0, IDL, '1, '0, 1'b0);
    chk("rst_hready", 32'(bus.HREADY), 32'd1);
    chk("rst_hresp",  32'(bus.HRESP),  32'd0);
    chk("rst_hrdata", bus.HRDATA,      32'hDEADBEEF);

    // Single read from slave 1
    step(32'h2000_0010, NSQ, '1, '0, 1'b0);
    chk("rd_hsel", 32'(bus.HSEL), 32'b000010);
    rd_next[32*1 +: 32] = 32'h1234_5678;
    step(32'h0, IDL, '1, '0, 1'b0);
    chk("rd_hrdata", bus.HRDATA,      32'h1234_5678);
    chk("rd_hready", 32'(bus.HREADY), 32'd1);

    // Slave 3 stalls three cycles while the next address targets page 0x00
    step(32'h4900_0000, NSQ, '1, '0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(32'h0000_0004, NSQ, 6'b110111, '0, 1'b0);
      chk("ws_hready", 32'(bus.HREADY), 32'd0);
      chk("ws_hsel",   32'(bus.HSEL),   32'b000001);
    end
    step(32'h0000_0004, NSQ, '1, '0, 1'b0);
    chk("ws_done", 32'(bus.HREADY), 32'd1);
    rd_next[32*0 +: 32] = 32'hA5A5_0000;
    step(32'h0, IDL, '1, '0, 1'b0);
    chk("ws_owner0", bus.HRDATA, 32'hA5A5_0000);

    // Unmapped active transfer
    step(32'h5000_0000, NSQ, '1, '0, 1'b0);
    step(32'h0, IDL, '1, '0, 1'b0);
`ifdef AHBL_BUS_MUX_ERR_EN
    chk("um_e1_hready", 32'(bus.HREADY), 32'd0);
    chk("um_e1_hresp",  32'(bus.HRESP),  32'd1);
    step(32'h0, IDL, '1, '0, 1'b0);
    chk("um_e2_hready", 32'(bus.HREADY), 32'd1);
    chk("um_e2_hresp",  32'(bus.HRESP),  32'd1);
    step(32'h0, IDL, '1, '0, 1'b0);
    chk("um_ok_hresp",  32'(bus.HRESP),  32'd0);
`else
    chk("um_hready", 32'(bus.HREADY), 32'd1);
    chk("um_hresp",  32'(bus.HRESP),  32'd0);
    chk("um_hrdata", bus.HRDATA,      32'hDEADBEEF);
`endif

    // IDLE to an unmapped page
    step(32'h5000_0000, IDL, '1, '0, 1'b0);
    step(32'h0, IDL, '1, '0, 1'b0);
    chk("idle_hready", 32'(bus.HREADY), 32'd1);
    chk("idle_hresp",  32'(bus.HRESP),  32'd0);

    // Reset while slave 4 is stalling with an ERROR pending
    step(32'h4A00_0000, NSQ, '1, '0, 1'b0);
    chk("rs_hsel", 32'(bus.HSEL), 32'b010000);
    step(32'h0, IDL, 6'b101111, 6'b010000, 1'b0);
    chk("rs_stall", 32'(bus.HREADY), 32'd0);
    step(32'h0, IDL, 6'b101111, 6'b010000, 1'b1);
    step(32'h0, IDL, 6'b101111, 6'b010000, 1'b0);
    chk("rs_hready", 32'(bus.HREADY), 32'd1);
    chk("rs_hresp",  32'(bus.HRESP),  32'd0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0]    a;
      logic [NS-1:0]  r;
      logic [NS-1:0]  rs;
      int             p;
      p = $urandom_range(0, 7);
      a = $urandom;
      if (p < NS)      a[31:24] = 8'(pages[p]);
      else if (p == 6) a[31:24] = 8'h50;
      for (int i = 0; i < NS; i++) begin
        r[i]  = ($urandom_range(0, 3) != 0);
        rs[i] = ($urandom_range(0, 7) == 0);
        rd_next[32*i +: 32] = $urandom;
      end
      step(a, 2'($urandom_range(0, 3)), r, rs, ($urandom_range(0, 63) == 0));
    end

    step(32'h0, IDL, '1, '0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
